bus_cycle_ctrl: RTL and testbench
=================================

Name: bus_cycle_ctrl

Overview:
Generates the CPU phase-2 clock from the master oscillator. Turns the active-low chip selects produced by the address decoder into registered read/write strobes for RAM, EEPROM and the PIA. Stretches the phi2-high phase on EEPROM accesses so that slow EEPROM parts meet access time. Sits between the address decoder and the memory/peripheral devices on the CPLD.

Parameters:
DIV, 4, master clocks per phi2-low phase and per unstretched phi2-high phase; legal range 2..15.
ROM_EXT, 4, extra master clocks added to the phi2-high phase when EEPROM is selected; legal range 0..15.
WE_GAP, 1, master clocks before the phi2 falling edge at which write strobes deassert; must be 1..DIV-1.

Ports:
clk  in  1  master clock
rst  in  1  asynchronous reset, active-high
rw  in  1  CPU R/W: 1 = read, 0 = write
ram_sel_n  in  1  RAM select from decoder, active-low
rom_sel_n  in  1  EEPROM select from decoder, active-low
pia_sel_n  in  1  PIA select from decoder, active-low
rom_wp  in  1  1 = EEPROM write-protected
phi2  out  1  CPU phase-2 clock, registered
ram_oe_n  out  1  RAM output enable, active-low, registered
ram_we_n  out  1  RAM write enable, active-low, registered
rom_oe_n  out  1  EEPROM output enable, active-low, registered
rom_we_n  out  1  EEPROM write enable, active-low, registered
pia_e  out  1  PIA enable (E) qualified by select, active-high, registered

Behaviour:
- Reset (asynchronous, immediate):
  - state = PH1, cnt = 0, phi2 = 0, pia_e = 0.
  - All *_oe_n and *_we_n = 1.
  - Reset mid-cycle aborts any strobe on the same instant; no glitch-free guarantee.
- States: PH1 (phi2 low) and PH2 (phi2 high). cnt counts master clocks within the phase; width is 5 bits.
- PH1:
  - Lasts exactly DIV clocks (cnt 0..DIV-1), all strobes inactive.
  - On the edge where cnt == DIV-1, the block samples rw, the three selects and rom_wp. Call these the cycle qualifiers. They are held constant for the whole of the following PH2.
  - Same edge: state -> PH2, cnt -> 0, phi2 -> 1.
- PH2 length:
  - L = DIV + ROM_EXT if the latched rom_sel_n == 0, else DIV.
  - PH2 ends on the edge where cnt == L-1: state -> PH1, cnt -> 0, phi2 -> 0, all strobes -> inactive on that same edge.
- Strobes change on the PH1->PH2 edge (same edge as phi2 rises), using the latched qualifiers:
  - rw=1 and ram_sel_n=0: ram_oe_n = 0 for all of PH2.
  - rw=1 and rom_sel_n=0: rom_oe_n = 0 for all of PH2.
  - rw=0 and ram_sel_n=0: ram_we_n = 0 from phi2 rise until the edge where cnt == L-1-WE_GAP, where it returns to 1.
  - rw=0, rom_sel_n=0 and rom_wp=0: rom_we_n behaves the same as ram_we_n. If rom_wp=1, rom_we_n stays 1.
  - pia_sel_n=0: pia_e = 1 for all of PH2, regardless of rw.
- No select active: phi2 still toggles with period 2*DIV and no strobe asserts.
- Multiple selects active at once (decoder fault): each strobe follows its own select independently. Stretch applies if rom_sel_n == 0.
- Select changes during PH2 are ignored. Only the sample at the end of PH1 matters.
- Cycle period: 2*DIV clocks normally, 2*DIV + ROM_EXT for EEPROM cycles. phi2 duty cycle is 50% except on stretched cycles.
- ROM_EXT = 0 gives an identical period for all cycles.

Test Plan:
- Reset then release, no selects, DIV=4 -> phi2 toggles every 4 clks, period 8; all strobes stay 1; pia_e stays 0.
- RAM read (rw=1, ram_sel_n=0 held) -> ram_oe_n = 0 exactly during each 4-clk phi2-high phase; ram_we_n stays 1.
- RAM write (rw=0, ram_sel_n=0), WE_GAP=1 -> ram_we_n low for 3 clks starting at the phi2 rise; it returns to 1 one clk before phi2 falls.
- EEPROM read, ROM_EXT=4 -> phi2 high for 8 clks, cycle period 12; rom_oe_n low for all 8 clks. Repeat with rom_sel_n toggled mid-PH2 -> no change in timing.
- EEPROM write with rom_wp=1 -> rom_we_n stays 1 and phi2 is still stretched to 8. With rom_wp=0 -> rom_we_n low for 7 clks.
- Assert rst during a stretched PH2 at cnt=5 -> phi2, strobes and pia_e go inactive immediately. After release, PH1 lasts 4 clks before the next rise.

Source files
------------

// File: rtl/bus_cycle_ctrl_if.sv
// Bus bundle between the address decoder, the cycle controller and the memory/peripheral strobes.
// The slave side is the cycle controller; the master side drives the decoder signals.
interface bus_cycle_ctrl_if;
  logic rw;
  logic ram_sel_n;
  logic rom_sel_n;
  logic pia_sel_n;
  logic rom_wp;
  logic phi2;
  logic ram_oe_n;
  logic ram_we_n;
  logic rom_oe_n;
  logic rom_we_n;
  logic pia_e;

  modport slave (
    input  rw, ram_sel_n, rom_sel_n, pia_sel_n, rom_wp,
    output phi2, ram_oe_n, ram_we_n, rom_oe_n, rom_we_n, pia_e
  );

  modport master (
    output rw, ram_sel_n, rom_sel_n, pia_sel_n, rom_wp,
    input  phi2, ram_oe_n, ram_we_n, rom_oe_n, rom_we_n, pia_e
  );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// Phase-2 clock generator and registered RAM/EEPROM/PIA strobe generator.
// EEPROM cycles get a longer phi2-high phase to meet slow part access times.
module bus_cycle_ctrl #(
  parameter int DIV     = 4,
  parameter int ROM_EXT = 4,
  parameter int WE_GAP  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bus_cycle_ctrl_if.slave       bus
);

  typedef enum logic {PH1, PH2} state_t;

  localparam logic [4:0] PH1_LAST  = 5'(DIV - 1);
  localparam logic [4:0] PH2_LAST  = 5'(DIV - 1);
  localparam logic [4:0] ROM_LAST  = 5'(DIV + ROM_EXT - 1);
  localparam logic [4:0] GAP       = 5'(WE_GAP);

  state_t     r_state;
  logic [4:0] r_cnt;
  logic       r_phi2;
  logic       r_ramOeN;
  logic       r_ramWeN;
  logic       r_romOeN;
  logic       r_romWeN;
  logic       r_piaE;
  logic       r_romCycle;

  state_t     w_stateNext;
  logic [4:0] w_cntNext;
  logic       w_phi2Next;
  logic       w_ramOeNNext;
  logic       w_ramWeNNext;
  logic       w_romOeNNext;
  logic       w_romWeNNext;
  logic       w_piaENext;
  logic       w_romCycleNext;
  logic [4:0] w_lenLast;
  logic [4:0] w_weOff;

  // Only the EEPROM select must survive past the rising edge: it sets the PH2 length.
  assign w_lenLast = r_romCycle ? ROM_LAST : PH2_LAST;
  assign w_weOff   = w_lenLast - GAP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= PH1;
      r_cnt      <= 5'd0;
      r_phi2     <= 1'b0;
      r_ramOeN   <= 1'b1;
      r_ramWeN   <= 1'b1;
      r_romOeN   <= 1'b1;
      r_romWeN   <= 1'b1;
      r_piaE     <= 1'b0;
      r_romCycle <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_phi2     <= w_phi2Next;
      r_ramOeN   <= w_ramOeNNext;
      r_ramWeN   <= w_ramWeNNext;
      r_romOeN   <= w_romOeNNext;
      r_romWeN   <= w_romWeNNext;
      r_piaE     <= w_piaENext;
      r_romCycle <= w_romCycleNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt + 5'd1;
    w_phi2Next     = r_phi2;
    w_ramOeNNext   = r_ramOeN;
    w_ramWeNNext   = r_ramWeN;
    w_romOeNNext   = r_romOeN;
    w_romWeNNext   = r_romWeN;
    w_piaENext     = r_piaE;
    w_romCycleNext = r_romCycle;

    case (r_state)
      PH1: begin
        if (r_cnt == PH1_LAST) begin
          // Qualifiers are sampled once here; decoder changes during PH2 are ignored.
          w_stateNext    = PH2;
          w_cntNext      = 5'd0;
          w_phi2Next     = 1'b1;
          w_romCycleNext = ~bus.rom_sel_n;
          w_ramOeNNext   = ~(bus.rw & ~bus.ram_sel_n);
          w_romOeNNext   = ~(bus.rw & ~bus.rom_sel_n);
          w_ramWeNNext   = ~(~bus.rw & ~bus.ram_sel_n);
          w_romWeNNext   = ~(~bus.rw & ~bus.rom_sel_n & ~bus.rom_wp);
          w_piaENext     = ~bus.pia_sel_n;
        end
      end
      PH2: begin
        if (r_cnt == w_lenLast) begin
          w_stateNext  = PH1;
          w_cntNext    = 5'd0;
          w_phi2Next   = 1'b0;
          w_ramOeNNext = 1'b1;
          w_ramWeNNext = 1'b1;
          w_romOeNNext = 1'b1;
          w_romWeNNext = 1'b1;
          w_piaENext   = 1'b0;
        end else if (r_cnt == w_weOff) begin
          w_ramWeNNext = 1'b1;
          w_romWeNNext = 1'b1;
        end
      end
      default: begin
        w_stateNext = PH1;
        w_cntNext   = 5'd0;
      end
    endcase
  end

  assign bus.phi2     = r_phi2;
  assign bus.ram_oe_n = r_ramOeN;
  assign bus.ram_we_n = r_ramWeN;
  assign bus.rom_oe_n = r_romOeN;
  assign bus.rom_we_n = r_romWeN;
  assign bus.pia_e    = r_piaE;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl with DIV=4, ROM_EXT=4, WE_GAP=1.
// Output vectors are {phi2, ram_oe_n, ram_we_n, rom_oe_n, rom_we_n, pia_e}.
module tb_bus_cycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;

  bus_cycle_ctrl_if busIf();

  bus_cycle_ctrl #(.DIV(4), .ROM_EXT(4), .WE_GAP(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf)
  );

  always #5 clk = ~clk;

  logic [5:0] obs;
  assign obs = {busIf.phi2, busIf.ram_oe_n, busIf.ram_we_n, busIf.rom_oe_n, busIf.rom_we_n, busIf.pia_e};

  localparam logic [5:0] IDLE_LO  = 6'b011110;
  localparam logic [5:0] IDLE_HI  = 6'b111110;
  localparam logic [5:0] RAM_RD   = 6'b101110;
  localparam logic [5:0] RAM_WR   = 6'b110110;
  localparam logic [5:0] ROM_RD   = 6'b111010;
  localparam logic [5:0] ROM_WR   = 6'b111100;
  localparam logic [5:0] PIA_ON   = 6'b111111;
  localparam logic [5:0] MULTI_RD = 6'b101011;

  task automatic applyStimulus(input logic rw, input logic ramN, input logic romN,
                               input logic piaN, input logic wp);
    busIf.rw        = rw;
    busIf.ram_sel_n = ramN;
    busIf.rom_sel_n = romN;
    busIf.pia_sel_n = piaN;
    busIf.rom_wp    = wp;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advances until the first sample where phi2 has just risen, bounded to 40 clocks.
  task automatic waitRise(output bit found);
    bit prev;
    prev  = busIf.phi2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (busIf.phi2 && !prev) found = 1'b1;
      prev = busIf.phi2;
    end
  endtask

  task automatic test_reset;
    logic [5:0] exp;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    testsRun++;
    if (obs !== IDLE_LO) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got %b expected %b", obs, IDLE_LO);
    end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp = (((k / 4) % 2) == 1) ? IDLE_HI : IDLE_LO;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL idle_toggle k=%0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_ram_read;
    bit found;
    logic [5:0] exp;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    waitRise(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL ram_read_rise: got no phi2 rise expected one within 40 clks");
    end
    for (int idx = 0; idx < 16; idx++) begin
      if (idx > 0) tick();
      exp = ((idx % 8) < 4) ? RAM_RD : IDLE_LO;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL ram_read idx=%0d: got %b expected %b", idx, obs, exp);
      end
    end
  endtask

  task automatic test_ram_write;
    bit found;
    logic [5:0] exp;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    waitRise(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL ram_write_rise: got no phi2 rise expected one within 40 clks");
    end
    for (int idx = 0; idx < 16; idx++) begin
      if (idx > 0) tick();
      exp = ((idx % 8) < 3) ? RAM_WR : ((idx % 8) < 4) ? IDLE_HI : IDLE_LO;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL ram_write idx=%0d: got %b expected %b", idx, obs, exp);
      end
    end
  endtask

  task automatic test_rom_read;
    bit found;
    logic [5:0] exp;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    waitRise(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL rom_read_rise: got no phi2 rise expected one within 40 clks");
    end
    for (int idx = 0; idx < 24; idx++) begin
      if (idx > 0) tick();
      exp = ((idx % 12) < 8) ? ROM_RD : IDLE_LO;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL rom_read idx=%0d: got %b expected %b", idx, obs, exp);
      end
    end
    // Select bounces during PH2 must not shorten the stretched phase.
    waitRise(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL rom_toggle_rise: got no phi2 rise expected one within 40 clks");
    end
    for (int idx = 0; idx < 12; idx++) begin
      if (idx > 0) tick();
      if (idx == 2) busIf.rom_sel_n = 1'b1;
      if (idx == 5) busIf.rom_sel_n = 1'b0;
      exp = (idx < 8) ? ROM_RD : IDLE_LO;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL rom_read_toggle idx=%0d: got %b expected %b", idx, obs, exp);
      end
    end
  endtask

  task automatic test_rom_write;
    bit found;
    logic [5:0] exp;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    waitRise(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL rom_wp_rise: got no phi2 rise expected one within 40 clks");
    end
    for (int idx = 0; idx < 12; idx++) begin
      if (idx > 0) tick();
      exp = (idx < 8) ? IDLE_HI : IDLE_LO;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL rom_write_wp idx=%0d: got %b expected %b", idx, obs, exp);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    waitRise(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL rom_write_rise: got no phi2 rise expected one within 40 clks");
    end
    for (int idx = 0; idx < 12; idx++) begin
      if (idx > 0) tick();
      exp = (idx < 7) ? ROM_WR : (idx < 8) ? IDLE_HI : IDLE_LO;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL rom_write idx=%0d: got %b expected %b", idx, obs, exp);
      end
    end
  endtask

  task automatic test_pia_multi;
    bit found;
    logic [5:0] exp;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    waitRise(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL pia_rise: got no phi2 rise expected one within 40 clks");
    end
    for (int idx = 0; idx < 8; idx++) begin
      if (idx > 0) tick();
      exp = (idx < 4) ? PIA_ON : IDLE_LO;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL pia_write idx=%0d: got %b expected %b", idx, obs, exp);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitRise(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL multi_rise: got no phi2 rise expected one within 40 clks");
    end
    for (int idx = 0; idx < 12; idx++) begin
      if (idx > 0) tick();
      exp = (idx < 8) ? MULTI_RD : IDLE_LO;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL multi_select idx=%0d: got %b expected %b", idx, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit found;
    logic [5:0] exp;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    waitRise(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL b2b_rise: got no phi2 rise expected one within 40 clks");
    end
    for (int idx = 0; idx < 20; idx++) begin
      if (idx > 0) tick();
      if (idx == 3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      if (idx < 8)       exp = ROM_RD;
      else if (idx < 12) exp = IDLE_LO;
      else if (idx < 16) exp = RAM_RD;
      else               exp = IDLE_LO;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL back_to_back idx=%0d: got %b expected %b", idx, obs, exp);
      end
    end
  endtask

  task automatic test_reset_midcycle;
    bit found;
    logic [5:0] exp;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    waitRise(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL midrst_rise: got no phi2 rise expected one within 40 clks");
    end
    for (int i = 0; i < 5; i++) tick();
    testsRun++;
    if (obs !== ROM_RD) begin
      testsFailed++;
      $display("[TB] FAIL midrst_before: got %b expected %b", obs, ROM_RD);
    end
    rst = 1'b1;
    #1;
    testsRun++;
    if (obs !== IDLE_LO) begin
      testsFailed++;
      $display("[TB] FAIL midrst_immediate: got %b expected %b", obs, IDLE_LO);
    end
    tick();
    tick();
    testsRun++;
    if (obs !== IDLE_LO) begin
      testsFailed++;
      $display("[TB] FAIL midrst_held: got %b expected %b", obs, IDLE_LO);
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = (k < 4) ? IDLE_LO : ROM_RD;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL midrst_release k=%0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    test_reset();
    test_ram_read();
    test_ram_write();
    test_rom_read();
    test_rom_write();
    test_pia_multi();
    test_back_to_back();
    test_reset_midcycle();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
